ep_reg_file: RTL and testbench

EP_REG_FILE -- requirements
Module: ep_reg_file

---
 rtl/ep_reg_file_if.sv | 36 +++
 rtl/ep_reg_file.sv | 194 +++++++++++++++++++
 tb/tb_ep_reg_file.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ep_reg_file_if.sv
// ---------------------------------------------------------------------------
// ep_reg_file_if
// Host-side register bus for the endpoint register file.
//
// Signals:
//   busAddr     host -> regfile   4-bit register address
//   busDataIn   host -> regfile   8-bit write data
//   busWEn      host -> regfile   write enable, qualified by busStrobe
//   busStrobe   host -> regfile   one-cycle access strobe
//   busDataOut  regfile -> host   registered read data (1-cycle latency)
//
// Modports: master (host side), slave (register file side).
// ---------------------------------------------------------------------------
interface ep_reg_file_if;
    logic [3:0] busAddr;
    logic [7:0] busDataIn;
    logic       busWEn;
    logic       busStrobe;
    logic [7:0] busDataOut;

    modport master (
        output busAddr,
        output busDataIn,
        output busWEn,
        output busStrobe,
        input  busDataOut
    );

    modport slave (
        input  busAddr,
        input  busDataIn,
        input  busWEn,
        input  busStrobe,
        output busDataOut
    );
endinterface

// File: rtl/ep_reg_file.sv
// ---------------------------------------------------------------------------
// ep_reg_file
// Host register file for the endpoint controller. Holds per-endpoint control
// bits, an interrupt status/mask pair and read-only views of endpoint status
// and transaction types. A rising edge on an endpoint's "transaction done"
// flag drops that endpoint's ready bit and latches its interrupt status bit.
//
// Ports:
//   clk                      clock, all state on rising edge
//   rst                      asynchronous active-low reset
//   bus                      host register bus (slave modport)
//   clrEPnRdy        (n=0..3) level done flags from the endpoint mux
//   endPnStatusReg   (n=0..3) 8-bit endpoint status (read-only view)
//   endPnTransTypeReg, endPnNAKTransTypeReg  2-bit transaction types
//   endPnControlReg  (n=0..3) 5-bit control: [0] enable, [1] ready,
//                            [2] outDataSeq, [3] sendStall, [4] isoEnable
//   epIntr                   registered level interrupt to the host
//
// Register map:
//   0x0-0x3  EPn control      RW, 5 bits, upper 3 read 0
//   0x4-0x7  EPn status       RO
//   0x8      intStatus        RW1C, bits[3:0]
//   0x9      intMask          RW, bits[3:0]
//   0xA      transType        RO, {EP3,EP2,EP1,EP0}
//   0xB      NAK transType    RO, {EP3,EP2,EP1,EP0}
//   0xC-0xF  reserved, read 0, writes ignored
// ---------------------------------------------------------------------------
module ep_reg_file #(
    parameter int NUM_EP = 4
) (
    input  logic              clk,
    input  logic              rst,

    ep_reg_file_if.slave      bus,

    input  logic              clrEP0Rdy,
    input  logic              clrEP1Rdy,
    input  logic              clrEP2Rdy,
    input  logic              clrEP3Rdy,

    input  logic [7:0]        endP0StatusReg,
    input  logic [7:0]        endP1StatusReg,
    input  logic [7:0]        endP2StatusReg,
    input  logic [7:0]        endP3StatusReg,

    input  logic [1:0]        endP0TransTypeReg,
    input  logic [1:0]        endP1TransTypeReg,
    input  logic [1:0]        endP2TransTypeReg,
    input  logic [1:0]        endP3TransTypeReg,

    input  logic [1:0]        endP0NAKTransTypeReg,
    input  logic [1:0]        endP1NAKTransTypeReg,
    input  logic [1:0]        endP2NAKTransTypeReg,
    input  logic [1:0]        endP3NAKTransTypeReg,

    output logic [4:0]        endP0ControlReg,
    output logic [4:0]        endP1ControlReg,
    output logic [4:0]        endP2ControlReg,
    output logic [4:0]        endP3ControlReg,

    output logic              epIntr
);

    localparam logic [3:0] ADDR_INT_STATUS = 4'h8;
    localparam logic [3:0] ADDR_INT_MASK   = 4'h9;
    localparam logic [3:0] ADDR_TRANS_TYPE = 4'hA;
    localparam logic [3:0] ADDR_NAK_TYPE   = 4'hB;

    localparam int CTRL_READY = 1;

    logic                   wr_en;
    logic                   rd_en;

    logic [NUM_EP-1:0]      clr_rdy_now;
    logic [NUM_EP-1:0]      clr_rdy_q;
    logic [NUM_EP-1:0]      done_pulse;

    logic [NUM_EP-1:0][4:0] ctrl_q;
    logic [NUM_EP-1:0][4:0] ctrl_d;

    logic [NUM_EP-1:0]      int_status_q;
    logic [NUM_EP-1:0]      int_status_d;
    logic [NUM_EP-1:0]      int_clr;
    logic [NUM_EP-1:0]      int_mask_q;
    logic [NUM_EP-1:0]      int_mask_d;

    logic                   ep_intr_q;
    logic                   ep_intr_d;

    logic [7:0]             bus_data_out_q;
    logic [7:0]             bus_data_out_d;
    logic [7:0]             rd_data;

    logic [NUM_EP-1:0][7:0] ep_status;
    logic [2*NUM_EP-1:0]    trans_type_packed;
    logic [2*NUM_EP-1:0]    nak_type_packed;

    // No register is wider than 5 bits, so the top of the write data is dropped.
    logic                   unused_wdata_hi;
    assign unused_wdata_hi = ^bus.busDataIn[7:5];

    assign wr_en = bus.busStrobe &  bus.busWEn;
    assign rd_en = bus.busStrobe & ~bus.busWEn;

    assign clr_rdy_now = {clrEP3Rdy, clrEP2Rdy, clrEP1Rdy, clrEP0Rdy};

    // History resets to 0, so a flag already high at reset release still
    // produces exactly one pulse on the first clock.
    assign done_pulse = clr_rdy_now & ~clr_rdy_q;

    assign ep_status[0] = endP0StatusReg;
    assign ep_status[1] = endP1StatusReg;
    assign ep_status[2] = endP2StatusReg;
    assign ep_status[3] = endP3StatusReg;

    assign trans_type_packed = {endP3TransTypeReg, endP2TransTypeReg,
                                endP1TransTypeReg, endP0TransTypeReg};
    assign nak_type_packed   = {endP3NAKTransTypeReg, endP2NAKTransTypeReg,
                                endP1NAKTransTypeReg, endP0NAKTransTypeReg};

    // Control registers: a host write loads all five bits, but a done pulse
    // in the same cycle still drops ready.
    always_comb begin
        ctrl_d = ctrl_q;
        for (int i = 0; i < NUM_EP; i++) begin
            if (wr_en && (bus.busAddr == 4'(i))) begin
                ctrl_d[i] = bus.busDataIn[4:0];
            end
            if (done_pulse[i]) begin
                ctrl_d[i][CTRL_READY] = 1'b0;
            end
        end
    end

    // Interrupt status: write-one-to-clear, with a same-cycle set winning.
    always_comb begin
        int_clr = '0;
        if (wr_en && (bus.busAddr == ADDR_INT_STATUS)) begin
            int_clr = bus.busDataIn[NUM_EP-1:0];
        end
        int_status_d = (int_status_q & ~int_clr) | done_pulse;
    end

    always_comb begin
        int_mask_d = int_mask_q;
        if (wr_en && (bus.busAddr == ADDR_INT_MASK)) begin
            int_mask_d = bus.busDataIn[NUM_EP-1:0];
        end
    end

    // Interrupt reflects the previous cycle's registered status and mask.
    assign ep_intr_d = |(int_status_q & int_mask_q);

    always_comb begin
        rd_data = 8'h00;
        case (bus.busAddr)
            4'h0, 4'h1, 4'h2, 4'h3: rd_data = {3'b000, ctrl_q[bus.busAddr[1:0]]};
            4'h4, 4'h5, 4'h6, 4'h7: rd_data = ep_status[bus.busAddr[1:0]];
            ADDR_INT_STATUS:        rd_data = {4'h0, int_status_q};
            ADDR_INT_MASK:          rd_data = {4'h0, int_mask_q};
            ADDR_TRANS_TYPE:        rd_data = trans_type_packed;
            ADDR_NAK_TYPE:          rd_data = nak_type_packed;
            default:                rd_data = 8'h00;
        endcase
    end

    assign bus_data_out_d = rd_en ? rd_data : bus_data_out_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_rdy_q      <= '0;
            ctrl_q         <= '0;
            int_status_q   <= '0;
            int_mask_q     <= '0;
            ep_intr_q      <= 1'b0;
            bus_data_out_q <= 8'h00;
        end else begin
            clr_rdy_q      <= clr_rdy_now;
            ctrl_q         <= ctrl_d;
            int_status_q   <= int_status_d;
            int_mask_q     <= int_mask_d;
            ep_intr_q      <= ep_intr_d;
            bus_data_out_q <= bus_data_out_d;
        end
    end

    assign bus.busDataOut   = bus_data_out_q;
    assign endP0ControlReg  = ctrl_q[0];
    assign endP1ControlReg  = ctrl_q[1];
    assign endP2ControlReg  = ctrl_q[2];
    assign endP3ControlReg  = ctrl_q[3];
    assign epIntr           = ep_intr_q;

endmodule

// File: tb/tb_ep_reg_file.sv
// ---------------------------------------------------------------------------
// tb_ep_reg_file
// Directed bench for ep_reg_file. Inputs change and outputs are sampled on
// the falling edge; the DUT updates on the rising edge.
// ---------------------------------------------------------------------------
module tb_ep_reg_file;

    logic       clk;
    logic       rst;
    logic       clrEP0Rdy, clrEP1Rdy, clrEP2Rdy, clrEP3Rdy;
    logic [7:0] endP0StatusReg, endP1StatusReg, endP2StatusReg, endP3StatusReg;
    logic [1:0] endP0TransTypeReg, endP1TransTypeReg, endP2TransTypeReg, endP3TransTypeReg;
    logic [1:0] endP0NAKTransTypeReg, endP1NAKTransTypeReg, endP2NAKTransTypeReg, endP3NAKTransTypeReg;
    logic [4:0] endP0ControlReg, endP1ControlReg, endP2ControlReg, endP3ControlReg;
    logic       epIntr;

    int n_checks;
    int n_pass;
    int n_fail;

    logic [7:0] rd;

    ep_reg_file_if bus_if ();

    ep_reg_file #(.NUM_EP(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .bus                  (bus_if),
        .clrEP0Rdy            (clrEP0Rdy),
        .clrEP1Rdy            (clrEP1Rdy),
        .clrEP2Rdy            (clrEP2Rdy),
        .clrEP3Rdy            (clrEP3Rdy),
        .endP0StatusReg       (endP0StatusReg),
        .endP1StatusReg       (endP1StatusReg),
        .endP2StatusReg       (endP2StatusReg),
        .endP3StatusReg       (endP3StatusReg),
        .endP0TransTypeReg    (endP0TransTypeReg),
        .endP1TransTypeReg    (endP1TransTypeReg),
        .endP2TransTypeReg    (endP2TransTypeReg),
        .endP3TransTypeReg    (endP3TransTypeReg),
        .endP0NAKTransTypeReg (endP0NAKTransTypeReg),
        .endP1NAKTransTypeReg (endP1NAKTransTypeReg),
        .endP2NAKTransTypeReg (endP2NAKTransTypeReg),
        .endP3NAKTransTypeReg (endP3NAKTransTypeReg),
        .endP0ControlReg      (endP0ControlReg),
        .endP1ControlReg      (endP1ControlReg),
        .endP2ControlReg      (endP2ControlReg),
        .endP3ControlReg      (endP3ControlReg),
        .epIntr               (epIntr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the next falling edge.
    task automatic bus_write(input logic [3:0] addr, input logic [7:0] data);
        bus_if.busAddr   = addr;
        bus_if.busDataIn = data;
        bus_if.busWEn    = 1'b1;
        bus_if.busStrobe = 1'b1;
        @(negedge clk);
        bus_if.busWEn    = 1'b0;
        bus_if.busStrobe = 1'b0;
    endtask

    // Called on a falling edge; data is registered at the following rising edge.
    task automatic bus_read(input logic [3:0] addr, output logic [7:0] data);
        bus_if.busAddr   = addr;
        bus_if.busWEn    = 1'b0;
        bus_if.busStrobe = 1'b1;
        @(negedge clk);
        bus_if.busStrobe = 1'b0;
        data = bus_if.busDataOut;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;

        rst = 1'b0;
        bus_if.busAddr   = 4'h0;
        bus_if.busDataIn = 8'h00;
        bus_if.busWEn    = 1'b0;
        bus_if.busStrobe = 1'b0;
        {clrEP0Rdy, clrEP1Rdy, clrEP2Rdy, clrEP3Rdy} = 4'b0000;
        endP0StatusReg = 8'h3C; endP1StatusReg = 8'h00;
        endP2StatusReg = 8'h00; endP3StatusReg = 8'h00;
        {endP0TransTypeReg, endP1TransTypeReg, endP2TransTypeReg, endP3TransTypeReg} = 8'h00;
        {endP0NAKTransTypeReg, endP1NAKTransTypeReg, endP2NAKTransTypeReg, endP3NAKTransTypeReg} = 8'h00;

        // Reset state
        #1;
        check("rst_dout", bus_if.busDataOut, 8'h00);
        check("rst_intr", {7'd0, epIntr}, 8'h00);
        check("rst_ctrl", {endP3ControlReg[1:0], endP2ControlReg[1:0], endP1ControlReg[1:0], endP0ControlReg[1:0]}, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Basic write/read of EP0 control
        bus_write(4'h0, 8'h03);
        check("ep0_ctrl_wr", {3'b0, endP0ControlReg}, 8'h03);
        bus_read(4'h0, rd);
        check("ep0_ctrl_rd", rd, 8'h03);
        @(negedge clk);
        check("dout_hold", bus_if.busDataOut, 8'h03);
        bus_write(4'h0, 8'hFF);
        bus_read(4'h0, rd);
        check("ep0_ctrl_upper0", rd, 8'h1F);

        // Writes to RO/reserved addresses are ignored
        bus_write(4'h4, 8'h00);
        bus_write(4'hC, 8'h00);
        check("ro_wr_ctrl0", {3'b0, endP0ControlReg}, 8'h1F);
        bus_read(4'hC, rd);
        check("rsvd_rd", rd, 8'h00);
        bus_read(4'h4, rd);
        check("ep0_status_rd", rd, 8'h3C);

        // EP1 done with flag held 5 cycles
        bus_write(4'h1, 8'h03);
        bus_write(4'h9, 8'h02);
        clrEP1Rdy = 1'b1;
        @(negedge clk);
        check("ep1_ready_clr", {3'b0, endP1ControlReg}, 8'h01);
        check("ep1_intr_lat1", {7'd0, epIntr}, 8'h00);
        @(negedge clk);
        check("ep1_intr_lat2", {7'd0, epIntr}, 8'h01);
        bus_write(4'h1, 8'h03);
        check("ep1_rewrite", {3'b0, endP1ControlReg}, 8'h03);
        @(negedge clk);
        @(negedge clk);
        check("ep1_single_pulse", {3'b0, endP1ControlReg}, 8'h03);
        clrEP1Rdy = 1'b0;
        bus_read(4'h8, rd);
        check("ep1_int_status", rd, 8'h02);
        bus_write(4'h8, 8'h02);
        @(negedge clk);
        check("intr_cleared", {7'd0, epIntr}, 8'h00);
        bus_read(4'h8, rd);
        check("int_status_w1c", rd, 8'h00);

        // Set beats a same-cycle clear
        clrEP1Rdy = 1'b1;
        @(negedge clk);
        clrEP1Rdy = 1'b0;
        @(negedge clk);
        clrEP1Rdy = 1'b1;
        bus_write(4'h8, 8'h02);
        bus_read(4'h8, rd);
        check("set_wins", rd, 8'h02);
        bus_write(4'h8, 8'h02);
        bus_read(4'h8, rd);
        check("clr_held_flag", rd, 8'h00);
        clrEP1Rdy = 1'b0;

        // EP2 write coincides with done pulse
        clrEP2Rdy = 1'b1;
        bus_write(4'h2, 8'h1B);
        check("ep2_clear_wins", {3'b0, endP2ControlReg}, 8'h19);
        bus_read(4'h2, rd);
        check("ep2_ctrl_rd", rd, 8'h19);
        clrEP2Rdy = 1'b0;

        // Mask register width
        bus_write(4'h9, 8'hFF);
        bus_read(4'h9, rd);
        check("mask_rd", rd, 8'h0F);

        // Read-only views
        endP3StatusReg = 8'hA5;
        endP0TransTypeReg = 2'd0; endP1TransTypeReg = 2'd1;
        endP2TransTypeReg = 2'd2; endP3TransTypeReg = 2'd3;
        endP0NAKTransTypeReg = 2'd3; endP1NAKTransTypeReg = 2'd2;
        endP2NAKTransTypeReg = 2'd1; endP3NAKTransTypeReg = 2'd0;
        bus_read(4'h7, rd);
        check("ep3_status_rd", rd, 8'hA5);
        bus_read(4'hA, rd);
        check("trans_type_rd", rd, 8'hE4);
        bus_read(4'hB, rd);
        check("nak_type_rd", rd, 8'h1B);

        // Async reset mid-access with all interrupts pending
        {clrEP0Rdy, clrEP1Rdy, clrEP2Rdy, clrEP3Rdy} = 4'b1111;
        @(negedge clk);
        bus_read(4'h8, rd);
        check("int_status_all", rd, 8'h0F);
        check("intr_all", {7'd0, epIntr}, 8'h01);
        bus_if.busAddr   = 4'h8;
        bus_if.busStrobe = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("arst_dout", bus_if.busDataOut, 8'h00);
        check("arst_intr", {7'd0, epIntr}, 8'h00);
        check("arst_ctrl0", {3'b0, endP0ControlReg}, 8'h00);
        check("arst_ctrl2", {3'b0, endP2ControlReg}, 8'h00);
        bus_if.busStrobe = 1'b0;
        {clrEP1Rdy, clrEP2Rdy, clrEP3Rdy} = 3'b000;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("no_pending_read", bus_if.busDataOut, 8'h00);
        bus_read(4'h8, rd);
        check("post_rst_int_status", rd, 8'h01);
        bus_read(4'h9, rd);
        check("post_rst_mask", rd, 8'h00);
        check("post_rst_intr", {7'd0, epIntr}, 8'h00);
        clrEP0Rdy = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
